// File: rtl/matrix_feeder.sv
// matrix_feeder: host-side sequencer for the 3x3 8-bit matrix multiplier.
// Holds the two operand matrices written by the host, pulses mm_start,
// streams the 18 operand bytes, then captures the 9 result bytes.
// Optional build macro: FEEDER_TIMEOUT_EN adds a WAIT-state watchdog that
// aborts the job after TIMEOUT cycles without mm_done.
module matrix_feeder #(
    parameter int N_IN    = 18,
    parameter int N_OUT   = 9,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       result_valid,
    output logic       err,
    output logic       mm_start,
    output logic [7:0] mm_data_in,
    input  logic [7:0] mm_data_out,
    input  logic       mm_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_FIN,
        S_ERR
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [4:0] cnt_inc;
    logic       busy_q, busy_d;
    logic       rv_q, rv_d;
    logic       err_q, err_d;
    logic       start_q, start_d;
    logic [7:0] din_q, din_d;

    logic [7:0] op_q  [N_IN];
    logic [7:0] res_q [N_OUT];
    logic       op_we;
    logic       res_we;
    logic [3:0] res_idx;

`ifdef FEEDER_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    // Next-state, counter, output and buffer-write decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + 5'd1;
        busy_d  = busy_q;
        rv_d    = rv_q;
        err_d   = err_q;
        start_d = 1'b0;
        din_d   = '0;
        op_we   = 1'b0;
        res_we  = 1'b0;
        res_idx = '0;
`ifdef FEEDER_TIMEOUT_EN
        wd_d    = wd_q;
`endif
        case (state_q)
            S_IDLE: begin
                op_we = wr_en && (wr_addr < 5'(N_IN));
                if (go) begin
                    state_d = S_START;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    rv_d    = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_START: begin
                // byte 0 is launched here so it is on the bus in the first SEND cycle
                state_d = S_SEND;
                cnt_d   = '0;
                din_d   = op_q[0];
            end
            S_SEND: begin
                cnt_d = cnt_inc;
                if (cnt_q == 5'(N_IN - 1)) begin
                    state_d = S_WAIT;
`ifdef FEEDER_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end else begin
                    din_d = op_q[cnt_inc];
                end
            end
            S_WAIT: begin
                if (mm_done) begin
                    state_d = S_RECV;
                    cnt_d   = '0;
                    res_we  = 1'b1;
                    res_idx = '0;
                end
`ifdef FEEDER_TIMEOUT_EN
                else begin
                    wd_d = wd_q + 1'b1;
                    if (wd_d == WD_W'(TIMEOUT)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
`endif
            end
            S_RECV: begin
                // counter restarts at 0 while slot 0 was already taken in WAIT,
                // so the slot written is one ahead of the counter
                cnt_d   = cnt_inc;
                res_we  = 1'b1;
                res_idx = cnt_inc[3:0];
                if (cnt_inc == 5'(N_OUT - 1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                // result_valid and the busy drop become visible together
                state_d = S_IDLE;
                busy_d  = 1'b0;
                rv_d    = 1'b1;
            end
            S_ERR: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            din_q   <= '0;
`ifdef FEEDER_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
            start_q <= start_d;
            din_q   <= din_d;
`ifdef FEEDER_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    // Operand and result storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (op_we) begin
            op_q[wr_addr] <= wr_data;
        end
        if (res_we) begin
            res_q[res_idx] <= mm_data_out;
        end
    end

    // Combinational result read; out-of-range slots read as zero
    always_comb begin
        rd_data = '0;
        if (rd_addr < 4'(N_OUT)) begin
            rd_data = res_q[rd_addr];
        end
    end

    assign busy         = busy_q;
    assign result_valid = rv_q;
    assign err          = err_q;
    assign mm_start     = start_q;
    assign mm_data_in   = din_q;

endmodule

// File: doc/matrix_feeder.md
# matrix_feeder

Host-side sequencer for the 3x3 8-bit matrix multiplier. It holds two operand matrices written by the host, pulses the multiplier's `start`, and streams the 18 operand bytes on the multiplier's `data_in`. It then waits for `done` and captures the 9 result bytes from `data_out` into a readable result buffer. It sits between the host register interface and the multiplier top.

## Interface
- `N_IN`, 18, operand bytes per job (A row-major at 0..8, then B row-major at 9..17)
- `N_OUT`, 9, result bytes per job (C row-major)
- `TIMEOUT`, 1024, watchdog limit in cycles; used only with `FEEDER_TIMEOUT_EN`
- `clk` in 1: single clock; all logic on the rising edge
- `rst` in 1: reset, asynchronous, active-low
- `go` in 1: host job request, single-cycle pulse
- `wr_en` in 1: host operand write strobe
- `wr_addr` in 5: operand index, 0..17
- `wr_data` in 8: operand byte
- `rd_addr` in 4: result index, 0..8
- `rd_data` out 8: result byte; combinational read of the result buffer
- `busy` out 1: job in progress
- `result_valid` out 1: result buffer holds a completed job
- `err` out 1: last job aborted by the watchdog
- `mm_start` out 1: to multiplier `start`
- `mm_data_in` out 8: to multiplier `data_in`
- `mm_data_out` in 8: from multiplier `data_out`
- `mm_done` in 1: from multiplier `done`

## Operation
- States and transitions:
  - IDLE: on `go`, go to START.
  - START: one cycle, then SEND.
  - SEND: 18 cycles, then WAIT.
  - WAIT: on `mm_done`, go to RECV and capture byte 0. With the watchdog enabled, go to ERR if `mm_done` does not arrive in time.
  - RECV: 8 more cycles, then FIN.
  - FIN: one cycle, then IDLE.
  - ERR: one cycle, then IDLE.
- `busy` is 1 in every state except IDLE.
- Operand buffer:
  - Written only in IDLE, when `wr_en` is high and `wr_addr` < 18.
  - Writes outside IDLE, or with out-of-range addresses, are dropped.
  - Storage is not reset.
- Byte counter:
  - 5 bits wide.
  - Cleared on entry to SEND and on entry to RECV.
  - Increments by 1 per cycle in SEND and in RECV.
  - Compared against 17 (SEND) and 8 (RECV) as terminal counts. It never wraps.
- Multiplier output protocol: the multiplier asserts `mm_done` with result byte 0 on `mm_data_out`, then presents bytes 1..8 on the next 8 consecutive cycles.
- Result capture: result byte k is written into result slot k.
- `result_valid`:
  - Cleared on `go` accepted.
  - Set on entry to FIN.
- `err`:
  - Cleared on `go` accepted.
  - Set on entry to ERR.
- `go` outside IDLE is ignored.
- `go` coincident with `wr_en` in IDLE: the write completes and the job uses the new byte.
- `mm_done` seen in START or SEND is ignored.
- `mm_done` seen in RECV or FIN has no effect.
- `rd_addr` > 8 returns 0.
- Reset while a job is running:
  - State returns to IDLE immediately.
  - All outputs go to their reset values.
  - Buffer contents are unspecified.

## Timing
- Reset values: `mm_start`=0, `mm_data_in`=0, `busy`=0, `result_valid`=0, `err`=0.
- All outputs except `rd_data` are registered.
- `go` sampled at edge 0 gives `mm_start`=1 for exactly cycle 1.
- `mm_data_in` carries operand byte k in cycle 2+k, for k = 0..17.
- `mm_data_in` returns to 0 from cycle 20 and holds 0 outside SEND.
- `mm_done` sampled high at edge t: bytes are captured at edges t..t+8.
- `result_valid` and `busy`=0 become visible 2 cycles after the last capture edge (t+10).
- Minimum job latency, `go` to `result_valid`: 20 cycles plus the multiplier's done delay plus 10.

## Configuration
- `FEEDER_TIMEOUT_EN` defined:
  - A 10+ bit watchdog counter is cleared on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT` without `mm_done`, the state goes to ERR.
  - On ERR, `err`=1, `result_valid` stays 0, and `busy` falls the next cycle.
- `FEEDER_TIMEOUT_EN` undefined:
  - No watchdog is built; WAIT lasts indefinitely.
  - `err` is tied to 0.

## Test plan
- Reset while in SEND: drive `rst`=0 asynchronously mid-stream -> `mm_start`, `mm_data_in`, `busy`, `result_valid` and `err` all read 0 before the next clock edge; the next `go` runs a full job.
- Stream order: write A=identity and B=1..9, then `go` -> `mm_start` high only in cycle 1; `mm_data_in` reads 1,0,0,0,1,0,0,0,1,1,2,...,9 over cycles 2..19, then 0.
- Capture: model `done` 5 cycles after the last byte, with `data_out`=1..9 -> `rd_data`[0..8] = 1..9; `result_valid`=1 and `busy`=0 ten cycles after `done`.
- Ignored requests: second `go` and `wr_en` (addr 0, data 0xFF) during SEND -> no restart and operand 0 unchanged; a spurious `done` in SEND does not alter the captured result.
- Boundaries: `wr_addr`=18 with data 0xAA -> no write; `rd_addr`=12 -> `rd_data`=0.
- Watchdog (`FEEDER_TIMEOUT_EN`, `TIMEOUT`=16): withhold `done` -> `err`=1 sixteen WAIT cycles after entry, `result_valid`=0, `busy`=0 one cycle later. Without the macro, `busy` stays 1 indefinitely.
